// File: rtl/uart_packet_tx_if.sv
// Write-side handshake bundle for uart_packet_tx: a host (master) offers bytes with an end-of-packet flag,
// and the transmitter (slave) answers with a registered ready.
interface uart_packet_tx_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/uart_packet_tx.sv
// Buffered 8N2 packet transmitter: bytes are queued with a last flag, sent LSB first, and every packet
// is closed by an idle gap long enough for the receiver to detect end-of-packet.
module uart_packet_tx #(
    parameter int ClkFrequency = 48000000,
    parameter int Baud         = 9600,
    parameter int FifoDepth    = 16,
    parameter int GapBits      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    uart_packet_tx_if.slave              wr,
    output logic                         TxD,
    output logic                         busy,
    output logic [$clog2(FifoDepth):0]   fifo_level,
    output logic                         pkt_done
);

    localparam int Divisor = (ClkFrequency + Baud / 2) / Baud;
    localparam int CntW    = $clog2(Divisor);
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int LvlW    = PtrW + 1;
    localparam int IdxW    = $clog2((GapBits > 8) ? GapBits : 8);

    localparam logic [CntW-1:0] MaxCnt     = CntW'(Divisor - 1);
    localparam logic [LvlW-1:0] FullLevel  = LvlW'(FifoDepth);
    localparam logic [IdxW-1:0] LastData   = IdxW'(7);
    localparam logic [IdxW-1:0] LastGapBit = IdxW'(GapBits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2, GAP} state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [8:0]      r_mem [FifoDepth];
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW-1:0] r_rdPtr;
    logic [LvlW-1:0] r_level;

    logic [CntW-1:0] r_timer;
    logic [IdxW-1:0] r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_lastQ;
    logic            r_txd;
    logic            r_pktDone;

    logic            w_push;
    logic            w_pop;
    logic            w_fifoEmpty;
    logic [8:0]      w_head;
    logic            w_bitEnd;
    logic            w_stateChange;
    logic            w_txdNext;
    logic            w_gapDone;

    assign wr.wr_ready   = (r_level != FullLevel);
    assign w_push        = wr.wr_valid && wr.wr_ready;
    assign w_fifoEmpty   = (r_level == '0);
    assign w_head        = r_mem[r_rdPtr];
    assign w_bitEnd      = (r_timer == MaxCnt);
    assign w_stateChange = (w_nextState != r_state);

    assign TxD        = r_txd;
    assign pkt_done   = r_pktDone;
    assign fifo_level = r_level;
    assign busy       = (r_state != IDLE) || !w_fifoEmpty;

    // Storage is flushed by clearing the pointers, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {wr.wr_last, wr.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PtrW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LvlW'(1);
                2'b01:   r_level <= r_level - LvlW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (!w_fifoEmpty) w_nextState = START;
            START: if (w_bitEnd) w_nextState = DATA;
            DATA:  if (w_bitEnd && r_bitIdx == LastData) w_nextState = STOP1;
            STOP1: if (w_bitEnd) w_nextState = STOP2;
            STOP2: begin
                if (w_bitEnd) begin
                    if (r_lastQ) begin
                        w_nextState = GAP;
                    end else if (!w_fifoEmpty) begin
                        w_nextState = START;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            GAP:     if (w_bitEnd && r_bitIdx == LastGapBit) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Line level and pops are decided from the current state; the line itself is registered one cycle later.
    always_comb begin
        w_txdNext = 1'b1;
        w_pop     = 1'b0;
        w_gapDone = 1'b0;
        case (r_state)
            IDLE:    w_pop     = !w_fifoEmpty;
            START:   w_txdNext = 1'b0;
            DATA:    w_txdNext = r_shift[0];
            STOP2:   w_pop     = w_bitEnd && !r_lastQ && !w_fifoEmpty;
            GAP:     w_gapDone = w_bitEnd && (r_bitIdx == LastGapBit);
            default: w_txdNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_lastQ   <= 1'b0;
            r_txd     <= 1'b1;
            r_pktDone <= 1'b0;
        end else begin
            r_txd     <= w_txdNext;
            r_pktDone <= w_gapDone;

            if (w_stateChange || r_state == IDLE || w_bitEnd) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + CntW'(1);
            end

            if (w_stateChange) begin
                r_bitIdx <= '0;
            end else if (w_bitEnd) begin
                r_bitIdx <= r_bitIdx + IdxW'(1);
            end

            if (w_pop) begin
                r_shift <= w_head[7:0];
                r_lastQ <= w_head[8];
            end else if (r_state == DATA && w_bitEnd) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

endmodule
